// File: rtl/frmclk_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : frmclk_pll_supervisor
// Brief    : Supervises the frame-clock PLL. Pulses the PLL reset, waits for
//            a stable lock, holds frame-clock consumers in reset until the
//            lock is good, retries on lock timeout and counts loss-of-lock.
// Revision : 1.0 - initial release
// ============================================================================
module frmclk_pll_supervisor #(
    parameter int RST_PULSE_CYCLES    = 120,
    parameter int LOCK_TIMEOUT_CYCLES = 120000,
    parameter int LOCK_STABLE_CYCLES  = 1200,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked_i,
    input  logic       force_relock_i,
    output logic       pll_rst_o,
    output logic       frm_rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] lol_cnt_o
);

    // Timer must hold the largest of the three cycle parameters.
    localparam int c_MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                               RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int c_MAX_CYC = (c_MAX_AB > LOCK_STABLE_CYCLES) ?
                               c_MAX_AB : LOCK_STABLE_CYCLES;
    localparam int c_TIMER_W = $clog2(c_MAX_CYC + 1);

    localparam logic [c_TIMER_W-1:0] c_RST_LAST = c_TIMER_W'(RST_PULSE_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TO_LAST  = c_TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_STB_LAST = c_TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]           c_RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL  = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE_CHK = 3'd2,
        S_READY      = 3'd3,
        S_FAILED     = 3'd4
    } state_t;

    state_t                 r_state_q,   w_state_d;
    logic [c_TIMER_W-1:0]   r_timer_q,   w_timer_d;
    logic [3:0]             r_retry_q,   w_retry_d;
    logic [7:0]             r_lol_q,     w_lol_d;
    logic                   r_sync1_q;
    logic                   r_slock_q;
    logic                   r_pll_rst_q, w_pll_rst_d;
    logic                   r_frm_rst_q, w_frm_rst_d;
    logic                   r_ready_q,   w_ready_d;
    logic                   r_fail_q,    w_fail_d;

    // Next-state, timer and counter logic; outputs are decoded from the next
    // state so they register on the same edge as the state itself.
    always_comb begin
        w_state_d = r_state_q;
        w_timer_d = r_timer_q + 1'b1;
        w_retry_d = r_retry_q;
        w_lol_d   = r_lol_q;

        if (force_relock_i && (r_state_q != S_RESET_PLL)) begin
            // Relock request wins over every lock/timer transition.
            w_state_d = S_RESET_PLL;
            w_timer_d = '0;
            w_retry_d = '0;
        end else begin
            case (r_state_q)
                S_RESET_PLL: begin
                    if (r_timer_q == c_RST_LAST) begin
                        w_state_d = S_WAIT_LOCK;
                        w_timer_d = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_slock_q) begin
                        w_state_d = S_STABLE_CHK;
                        w_timer_d = '0;
                    end else if (r_timer_q == c_TO_LAST) begin
                        w_timer_d = '0;
                        if (r_retry_q >= c_RETRY_MAX) begin
                            w_state_d = S_FAILED;
                        end else begin
                            w_state_d = S_RESET_PLL;
                            w_retry_d = r_retry_q + 4'd1;
                        end
                    end
                end
                S_STABLE_CHK: begin
                    if (!r_slock_q) begin
                        // Glitch during qualification: fresh timeout, no retry charged.
                        w_state_d = S_WAIT_LOCK;
                        w_timer_d = '0;
                    end else if (r_timer_q == c_STB_LAST) begin
                        w_state_d = S_READY;
                        w_timer_d = '0;
                    end
                end
                S_READY: begin
                    w_timer_d = r_timer_q;
                    if (!r_slock_q) begin
                        w_state_d = S_RESET_PLL;
                        w_timer_d = '0;
                        w_retry_d = '0;
                        if (r_lol_q != 8'hFF) begin
                            w_lol_d = r_lol_q + 8'd1;
                        end
                    end
                end
                S_FAILED: begin
                    w_timer_d = r_timer_q;
                end
                default: begin
                    w_state_d = S_RESET_PLL;
                    w_timer_d = '0;
                end
            endcase
        end

        w_pll_rst_d = (w_state_d == S_RESET_PLL);
        w_ready_d   = (w_state_d == S_READY);
        w_frm_rst_d = (w_state_d != S_READY);
        w_fail_d    = (w_state_d == S_FAILED);
    end

    // State, counters, lock synchronizer and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state_q   <= S_RESET_PLL;
            r_timer_q   <= '0;
            r_retry_q   <= '0;
            r_lol_q     <= '0;
            r_sync1_q   <= 1'b0;
            r_slock_q   <= 1'b0;
            r_pll_rst_q <= 1'b1;
            r_frm_rst_q <= 1'b1;
            r_ready_q   <= 1'b0;
            r_fail_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_timer_q   <= w_timer_d;
            r_retry_q   <= w_retry_d;
            r_lol_q     <= w_lol_d;
            r_sync1_q   <= pll_locked_i;
            r_slock_q   <= r_sync1_q;
            r_pll_rst_q <= w_pll_rst_d;
            r_frm_rst_q <= w_frm_rst_d;
            r_ready_q   <= w_ready_d;
            r_fail_q    <= w_fail_d;
        end
    end

    assign pll_rst_o   = r_pll_rst_q;
    assign frm_rst_o   = r_frm_rst_q;
    assign ready_o     = r_ready_q;
    assign fail_o      = r_fail_q;
    assign retry_cnt_o = r_retry_q;
    assign lol_cnt_o   = r_lol_q;

endmodule
`default_nettype wire

// File: tb/tb_frmclk_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_frmclk_pll_supervisor
// Brief    : Directed self-checking bench for frmclk_pll_supervisor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frmclk_pll_supervisor;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       force_relock_i = 1'b0;
    logic       pll_rst_o;
    logic       frm_rst_o;
    logic       ready_o;
    logic       fail_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] lol_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    frmclk_pll_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) u_dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked_i   (pll_locked_i),
        .force_relock_i (force_relock_i),
        .pll_rst_o      (pll_rst_o),
        .frm_rst_o      (frm_rst_o),
        .ready_o        (ready_o),
        .fail_o         (fail_o),
        .retry_cnt_o    (retry_cnt_o),
        .lol_cnt_o      (lol_cnt_o)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // One reset edge; afterwards the bench sits just past edge E0.
    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"}, pll_rst_o, 1);
        check({tag, "_frm_rst"}, frm_rst_o, 1);
        check({tag, "_ready"},   ready_o,   0);
        check({tag, "_fail"},    fail_o,    0);
        check({tag, "_retry"},   retry_cnt_o, 0);
        check({tag, "_lol"},     lol_cnt_o, 0);
    endtask

    task automatic wait_ready(input logic val, input int budget, input string tag);
        int k = 0;
        while (ready_o !== val && k < budget) begin
            step(1);
            k++;
        end
        check(tag, ready_o, val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lol_model;
        int pulses;
        int hi_cycles;
        logic prev;

        // ---------------- lock acquisition and loss-of-lock ----------------
        do_reset();                         // E0
        check_reset_vals("rst0");
        step(3);                            // E3
        check("pulse_last", pll_rst_o, 1);
        step(1);                            // E4
        check("pulse_end", pll_rst_o, 0);
        step(5);                            // E9: lock first sampled at E10
        pll_locked_i = 1'b1;
        step(10);                           // E19
        check("ready_early", ready_o, 0);
        step(1);                            // E20
        check("ready_on", ready_o, 1);
        check("frm_rst_off", frm_rst_o, 0);
        check("pll_rst_ready", pll_rst_o, 0);
        pll_locked_i = 1'b0;                // drop first sampled at E21
        step(2);                            // E22
        check("ready_hold", ready_o, 1);
        step(1);                            // E23
        check("lol_ready", ready_o, 0);
        check("lol_frm_rst", frm_rst_o, 1);
        check("lol_cnt1", lol_cnt_o, 1);
        check("lol_pll_rst", pll_rst_o, 1);
        step(3);                            // E26
        check("lol_pulse_last", pll_rst_o, 1);
        step(1);                            // E27
        check("lol_pulse_end", pll_rst_o, 0);

        lol_model = 1;
        for (int i = 0; i < 255; i++) begin
            pll_locked_i = 1'b1;
            wait_ready(1'b1, 64, "relock");
            pll_locked_i = 1'b0;
            wait_ready(1'b0, 16, "lol_drop");
            lol_model = (lol_model < 255) ? lol_model + 1 : 255;
            check("lol_cnt", lol_cnt_o, lol_model);
        end
        check("lol_sat", lol_cnt_o, 255);

        // ---------------- lock glitch during qualification -----------------
        do_reset();                         // E0
        check("rst1_lol", lol_cnt_o, 0);
        pll_locked_i = 1'b1;                // sampled from E1
        step(8);                            // E8: stable count 3
        check("glitch_pre", ready_o, 0);
        pll_locked_i = 1'b0;                // low at E9,E10,E11
        step(3);                            // E11: back in WAIT_LOCK
        check("glitch_ready", ready_o, 0);
        check("glitch_retry", retry_cnt_o, 0);
        check("glitch_lol", lol_cnt_o, 0);
        check("glitch_pll_rst", pll_rst_o, 0);
        pll_locked_i = 1'b1;
        step(10);                           // E21
        check("glitch_ready_early", ready_o, 0);
        step(1);                            // E22
        check("glitch_ready_on", ready_o, 1);
        check("glitch_lol_after", lol_cnt_o, 0);

        // ---------------- permanent no-lock, retries, failure --------------
        pll_locked_i = 1'b0;
        do_reset();                         // E0
        prev = pll_rst_o;
        pulses = 1;
        hi_cycles = 1;
        for (int k = 1; k <= 140; k++) begin
            step(1);
            if (pll_rst_o && !prev) pulses++;
            if (pll_rst_o) hi_cycles++;
            prev = pll_rst_o;
            if (k == 35)  check("retry_before1", retry_cnt_o, 0);
            if (k == 36)  begin
                check("retry1", retry_cnt_o, 1);
                check("retry1_pulse", pll_rst_o, 1);
            end
            if (k == 72)  check("retry2", retry_cnt_o, 2);
            if (k == 107) check("fail_early", fail_o, 0);
            if (k == 108) begin
                check("fail_on", fail_o, 1);
                check("fail_pll_rst", pll_rst_o, 0);
            end
        end
        check("pulse_count", pulses, 3);
        check("pulse_cycles", hi_cycles, 12);
        check("fail_sticky", fail_o, 1);
        check("fail_retry", retry_cnt_o, 2);
        check("fail_frm_rst", frm_rst_o, 1);

        // ---------------- force relock from FAILED -------------------------
        force_relock_i = 1'b1;
        step(1);                            // F1
        force_relock_i = 1'b0;
        check("force_fail", fail_o, 0);
        check("force_retry", retry_cnt_o, 0);
        check("force_pll_rst", pll_rst_o, 1);
        force_relock_i = 1'b1;              // ignored inside RESET_PLL
        step(1);                            // F2
        force_relock_i = 1'b0;
        check("force_ign", pll_rst_o, 1);
        step(2);                            // F4
        check("force_pulse_last", pll_rst_o, 1);
        step(1);                            // F5: WAIT_LOCK
        check("force_pulse_end", pll_rst_o, 0);

        // ---------------- reset while in WAIT_LOCK with retry=1 ------------
        step(32);                           // timeout -> retry 1
        check("wait_retry1", retry_cnt_o, 1);
        check("wait_retry1_pulse", pll_rst_o, 1);
        step(4);                            // back in WAIT_LOCK
        check("wait_retry1_wait", pll_rst_o, 0);
        do_reset();
        check_reset_vals("rst_mid");
        step(3);
        check("rst_mid_pulse_last", pll_rst_o, 1);
        step(1);
        check("rst_mid_pulse_end", pll_rst_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frmclk_pll_supervisor.md
FRMCLK_PLL_SUPERVISOR -- requirements
Module: frmclk_pll_supervisor

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 120, number of cycles pll_rst_o is held high per PLL reset attempt (1 us at 120 MHz).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 120000, number of cycles to wait for lock after a PLL reset pulse.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1200, number of consecutive synchronized-locked cycles required before the lock is declared good.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, number of lock-timeout retries allowed before the block declares failure.
REQ-005 SHALL have port refclk, input, 1 bit: the single clock, the 120 MHz frame-PLL reference; all logic is on rising refclk.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked_i, input, 1 bit: PLL locked flag, asynchronous to refclk.
REQ-008 SHALL have port force_relock_i, input, 1 bit: single-cycle request to restart the lock sequence.
REQ-009 SHALL have port pll_rst_o, output, 1 bit: reset to the frame-clock PLL.
REQ-010 SHALL have port frm_rst_o, output, 1 bit: reset for frame-clock consumers; low only while the lock is good.
REQ-011 SHALL have ports ready_o (1 bit, lock good), fail_o (1 bit, sticky failure), retry_cnt_o (4 bits) and lol_cnt_o (8 bits, loss-of-lock events), all outputs.

Function
REQ-012 SHALL pass pll_locked_i through a 2-flop synchronizer; "slock" below is the second flop's output, lagging the input by 2 cycles.
REQ-013 SHALL implement the states RESET_PLL, WAIT_LOCK, STABLE_CHK, READY and FAILED, using one shared cycle timer cleared on every state entry.
REQ-014 RESET_PLL: SHALL drive pll_rst_o=1 for exactly RST_PULSE_CYCLES cycles, then enter WAIT_LOCK.
REQ-015 WAIT_LOCK: on slock=1 SHALL enter STABLE_CHK.
REQ-016 WAIT_LOCK: if slock stays 0 for LOCK_TIMEOUT_CYCLES cycles, SHALL enter FAILED when retry_cnt_o==MAX_RETRIES; otherwise it SHALL increment retry_cnt_o and enter RESET_PLL.
REQ-017 STABLE_CHK: SHALL enter READY after LOCK_STABLE_CYCLES consecutive slock=1 cycles.
REQ-018 STABLE_CHK: any slock=0 SHALL return the block to WAIT_LOCK with a fresh timeout, leaving retry_cnt_o and lol_cnt_o unchanged.
REQ-019 READY: slock=0 SHALL increment lol_cnt_o (saturating at 255), clear retry_cnt_o and enter RESET_PLL.
REQ-020 FAILED: SHALL be sticky; only rst or force_relock_i leaves it.
REQ-021 force_relock_i=1 in any state other than RESET_PLL SHALL clear retry_cnt_o and fail_o and enter RESET_PLL; in RESET_PLL it SHALL be ignored.
REQ-022 force_relock_i SHALL take priority over the slock and timer transitions in the same cycle.
REQ-023 All outputs SHALL be registered and change on the same edge as the state register.
REQ-024 Output decode by state: pll_rst_o=1 only in RESET_PLL; ready_o=1 and frm_rst_o=0 only in READY, with frm_rst_o=1 in every other state; fail_o=1 only in FAILED.
REQ-025 The timer SHALL be wide enough for the largest of the three cycle parameters; retry_cnt_o SHALL never exceed MAX_RETRIES.

Reset
REQ-026 With rst=1 at a refclk edge, the block SHALL enter RESET_PLL with timer=0, pll_rst_o=1, frm_rst_o=1, ready_o=0, fail_o=0, retry_cnt_o=0, lol_cnt_o=0 and both synchronizer flops cleared.
REQ-027 Reset asserted mid-operation in any state SHALL produce the REQ-026 values on the next edge and restart a full RST_PULSE_CYCLES pulse after release.

Verification (RST_PULSE=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRIES=2)
REQ-028 Release rst, raise pll_locked_i at cycle 10 and hold it -> pll_rst_o high for cycles 0-3; ready_o=1 and frm_rst_o=0 from 10 cycles after the lock rise (2 sync + 8 stable).
REQ-029 Hold pll_locked_i=0 permanently -> exactly 3 pll_rst_o pulses of 4 cycles; retry_cnt_o counts 1 then 2; fail_o=1 after 108 cycles; pll_rst_o stays 0 afterwards.
REQ-030 Drop pll_locked_i for 3 cycles at stable count 5 -> no ready_o, lol_cnt_o=0, retry_cnt_o unchanged; ready_o asserts only after a fresh run of 8 stable cycles.
REQ-031 Drop pll_locked_i while READY -> 2 cycles later ready_o=0, frm_rst_o=1, lol_cnt_o=1 and a 4-cycle pll_rst_o pulse; 256 such events leave lol_cnt_o at 255.
REQ-032 Pulse force_relock_i while FAILED -> next edge fail_o=0, retry_cnt_o=0, pll_rst_o=1 for 4 cycles.
REQ-033 Assert rst in WAIT_LOCK with retry_cnt_o=1 -> next edge shows all REQ-026 values.
